fpga_ip_demo_irq_ctrl: RTL

Avalon-MM interrupt controller sitting directly downstream of the system clock timer and peer peripherals. Collects up to 16 peripheral irq lines (timer irq on bit 0), latches them as pending per source in level or edge mode, and applies a mask. Drives a single registered irq to the CPU. Provides a priority vector register so the ISR finds the serviced source in one read.

---
 rtl/fpga_ip_demo_irq_ctrl_if.sv | 28 ++
 rtl/fpga_ip_demo_irq_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fpga_ip_demo_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt controller register file.
// Latency: n/a (wiring only); readdata is produced registered by the slave.
// Backpressure: none, Avalon fixed read latency 1 with no waitrequest.
interface fpga_ip_demo_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  // CPU / bus-fabric side drives the command, receives read data
  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  // Controller side decodes the command, returns read data
  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/fpga_ip_demo_irq_ctrl.sv
// Interrupt controller: latches up to 16 irq sources (level/edge), masks, drives one registered irq and a priority vector.
// Latency: input rise -> pending same edge, irq one edge later; +2 edges with IRQ_CTRL_SYNC_EN (input synchroniser); read latency 1.
// Backpressure: none; every Avalon access completes in one cycle, no waitrequest.
module fpga_ip_demo_irq_ctrl #(
  parameter int          N_IRQ    = 8,
  parameter logic [15:0] VEC_NONE = 16'h8000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fpga_ip_demo_irq_ctrl_if.slave bus,
  input  logic [N_IRQ-1:0]     irq_in,
  output logic                 irq
);

  // Register addresses
  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_EDGE    = 3'd2;
  localparam logic [2:0] A_VECTOR  = 3'd3;
  localparam logic [2:0] A_RAW     = 3'd4;
  localparam logic [2:0] A_FORCE   = 3'd5;

  // Source bits in use; upper bits of every register are held at 0.
  // All state is kept 16 bits wide with those bits forced to 0 so the register
  // map and write data handling are uniform for any N_IRQ.
  localparam logic [15:0] VALID_MASK =
    (N_IRQ >= 16) ? 16'hFFFF : 16'((32'd1 << N_IRQ) - 32'd1);

  logic [15:0] irq_raw;
  logic [15:0] irq_s;
  logic [15:0] wdata_valid;

  logic        wr_en;
  logic        wr_pending;
  logic        wr_mask;
  logic        wr_edge;
  logic        wr_force;

  logic [15:0] pending_q, pending_d;
  logic [15:0] mask_q,    mask_d;
  logic [15:0] edge_sel_q, edge_sel_d;
  logic [15:0] irq_d_q;
  logic [15:0] readdata_q, readdata_d;
  logic        irq_q;

  logic [15:0] set_vec;
  logic [15:0] clr_vec;
  logic [15:0] active;
  logic [15:0] vector;

  assign irq_raw     = 16'(irq_in) & VALID_MASK;
  assign wdata_valid = bus.writedata & VALID_MASK;

  // Write strobes: one-cycle Avalon writes, no waitrequest
  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign wr_pending = wr_en & (bus.address == A_PENDING);
  assign wr_mask    = wr_en & (bus.address == A_MASK);
  assign wr_edge    = wr_en & (bus.address == A_EDGE);
  assign wr_force   = wr_en & (bus.address == A_FORCE);

`ifdef IRQ_CTRL_SYNC_EN
  logic [15:0] sync1_q;
  logic [15:0] sync2_q;

  // Two-flop synchroniser per source for irqs generated in foreign clock domains
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_raw;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_raw;
`endif

  // Per-source set/clear; a set in the same cycle as a W1C wins so no event is lost.
  // The edge detector always tracks irq_s, so switching a high source to edge
  // mode does not fabricate a rising edge.
  always_comb begin
    set_vec = (edge_sel_q & irq_s & ~irq_d_q) | (~edge_sel_q & irq_s);
    if (wr_force) begin
      set_vec = set_vec | wdata_valid;
    end
    clr_vec = '0;
    if (wr_pending) begin
      clr_vec = wdata_valid;
    end
    pending_d = ((pending_q & ~clr_vec) | set_vec) & VALID_MASK;
  end

  // Control register next state
  always_comb begin
    mask_d     = mask_q;
    edge_sel_d = edge_sel_q;
    if (wr_mask) begin
      mask_d = wdata_valid;
    end
    if (wr_edge) begin
      edge_sel_d = wdata_valid;
    end
  end

  assign active = pending_q & mask_q;

  // Priority encoder: lowest-index active source wins (bit 0, the timer, is highest)
  always_comb begin
    vector = VEC_NONE;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        vector = 16'(i);
      end
    end
  end

  // Read mux, registered unconditionally every clock for a fixed latency of 1
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      A_PENDING: readdata_d = pending_q;
      A_MASK:    readdata_d = mask_q;
      A_EDGE:    readdata_d = edge_sel_q;
      A_VECTOR:  readdata_d = vector;
      A_RAW:     readdata_d = irq_s;
      default:   readdata_d = '0;
    endcase
  end

  // State registers; async reset also drops irq immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      irq_d_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      irq_d_q    <= irq_s;
      readdata_q <= readdata_d;
      irq_q      <= |active;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
